cic3_integrators: RTL and testbench

Front half of the third-order cascaded integrator-comb (CIC) decimator. It accumulates the 1-bit sigma-delta modulator bitstream through three cascaded integrators at the modulator clock rate. It decimates by `DECIMATION_FACTOR`, presenting the downsampled third-integral on `out`. It also generates the divided clock that the downstream differentiator (comb) stage runs on.

---
 rtl/cic3_integrators.sv | 77 +++++++
 tb/tb_cic3_integrators.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cic3_integrators.sv
// Integrator half of a third-order CIC decimator: three cascaded modulo accumulators on the
// 1-bit modulator stream, a decimation capture of the third integral, and the comb-stage clock.
module cic3_integrators #(
  parameter int unsigned DECIMATION_FACTOR = 256,
  parameter int unsigned CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
  parameter int unsigned NUMBITS           = 3 * CLOCK_WIDTH + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_i,
  input  logic               enable_i,
  output logic [NUMBITS-1:0] out_o,
  output logic               divided_clk_o,
  output logic               sample_valid_o
);

  localparam logic [CLOCK_WIDTH-1:0] LastCount = CLOCK_WIDTH'(DECIMATION_FACTOR - 1);
  localparam logic [CLOCK_WIDTH-1:0] HalfCount = CLOCK_WIDTH'(DECIMATION_FACTOR / 2);

  logic [NUMBITS-1:0]     acc1_q, acc1_d;
  logic [NUMBITS-1:0]     acc2_q, acc2_d;
  logic [NUMBITS-1:0]     acc3_q, acc3_d;
  logic [NUMBITS-1:0]     out_q, out_d;
  logic [CLOCK_WIDTH-1:0] count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   div_clk_q, div_clk_d;
  logic                   capture;

  assign capture = enable_i && (count_q == LastCount);

  always_comb begin
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    acc3_d    = acc3_q;
    out_d     = out_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    div_clk_d = div_clk_q;
    if (enable_i) begin
      // Each stage consumes the pre-edge value of the previous one; wrap is intentional.
      acc1_d    = acc1_q + NUMBITS'(in_i);
      acc2_d    = acc2_q + acc1_q;
      acc3_d    = acc3_q + acc2_q;
      count_d   = count_q + CLOCK_WIDTH'(1);
      div_clk_d = (count_d < HalfCount);
      if (capture) begin
        out_d   = acc3_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc1_q    <= '0;
      acc2_q    <= '0;
      acc3_q    <= '0;
      out_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      div_clk_q <= 1'b0;
    end else begin
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      acc3_q    <= acc3_d;
      out_q     <= out_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      div_clk_q <= div_clk_d;
    end
  end

  assign out_o          = out_q;
  assign sample_valid_o = valid_q;
  assign divided_clk_o  = div_clk_q;

endmodule

// File: tb/tb_cic3_integrators.sv
// Randomized bench for cic3_integrators at D=8 and D=256 against a closed-form CIC model.
module tb_cic3_integrators;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_b = 1'b0;
  logic en = 1'b0;

  logic [9:0]  out8;
  logic        sv8, dc8;
  logic [24:0] out256;
  logic        sv256, dc256;

  int n_checks = 0;
  int n_pass = 0;

  cic3_integrators #(.DECIMATION_FACTOR(8)) dut8 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_i           (in_b),
    .enable_i       (en),
    .out_o          (out8),
    .divided_clk_o  (dc8),
    .sample_valid_o (sv8)
  );

  cic3_integrators #(.DECIMATION_FACTOR(256)) dut256 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_i           (in_b),
    .enable_i       (en),
    .out_o          (out256),
    .divided_clk_o  (dc256),
    .sample_valid_o (sv256)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: history of inputs on enabled edges since reset, per instance.
  bit     hist [2][4096];
  int     m_e [2];
  longint m_out [2];
  bit     m_sv [2];
  bit     m_dc [2];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Third integral after k edges: each input i contributes C(k-1-i, 2).
  function automatic longint ref_acc3(input int idx, input int k, input int nb);
    longint s = 0;
    for (int i = 0; i < k; i++) begin
      longint m = longint'(k - 1 - i);
      if (hist[idx][i]) s += m * (m - 1) / 2;
    end
    return s & ((longint'(1) << nb) - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_e[i] = 0; m_out[i] = 0; m_sv[i] = 1'b0; m_dc[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int idx, input int d, input int nb);
    if (!rst_n) begin
      m_e[idx] = 0; m_out[idx] = 0; m_sv[idx] = 1'b0; m_dc[idx] = 1'b0;
    end else if (!en) begin
      m_sv[idx] = 1'b0;
    end else begin
      if (m_e[idx] < 4096) hist[idx][m_e[idx]] = in_b;
      m_e[idx]++;
      if (m_e[idx] % d == 0) begin
        m_out[idx] = ref_acc3(idx, m_e[idx] - 1, nb);
        m_sv[idx]  = 1'b1;
      end else begin
        m_sv[idx]  = 1'b0;
      end
      m_dc[idx] = ((m_e[idx] % d) < (d / 2));
    end
  endtask

  task automatic check_all();
    check("out8", longint'(out8), m_out[0]);
    check("sv8", longint'(sv8), longint'(m_sv[0]));
    check("dc8", longint'(dc8), longint'(m_dc[0]));
    check("out256", longint'(out256), m_out[1]);
    check("sv256", longint'(sv256), longint'(m_sv[1]));
    check("dc256", longint'(dc256), longint'(m_dc[1]));
  endtask

  task automatic step(input bit v_in, input bit v_en);
    in_b = v_in;
    en   = v_en;
    @(posedge clk);
    #1;
    model_edge(0, 8, 10);
    model_edge(1, 256, 25);
    check_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic areset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_out8", longint'(out8), 0);
    check("arst_sv8", longint'(sv8), 0);
    check("arst_dc8", longint'(dc8), 0);
    check("arst_out256", longint'(out256), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int last_pulse;
    model_reset();

    // Reset held while clocking with active inputs.
    en = 1'b1; in_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_out8", longint'(out8), 0);
      check("rst_sv8", longint'(sv8), 0);
      check("rst_dc8", longint'(dc8), 0);
      check("rst_out256", longint'(out256), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Constant ones, D=8.
    for (int i = 1; i <= 24; i++) begin
      step(1'b1, 1'b1);
      if (i == 1) check("dc_edge1", longint'(dc8), 1);
      if (i == 4) check("dc_edge4", longint'(dc8), 0);
      if (i == 8) begin
        check("dc_edge8", longint'(dc8), 1);
        check("ones_cap8", longint'(out8), 35);
        check("ones_sv8", longint'(sv8), 1);
      end
      if (i == 9)  check("ones_sv9", longint'(sv8), 0);
      if (i == 16) check("ones_cap16", longint'(out8), 455);
      if (i == 24) check("ones_cap24", longint'(out8), 747);
    end

    // Single 1 on the first edge, then zeros.
    areset();
    step(1'b1, 1'b1);
    for (int i = 2; i <= 16; i++) step(1'b0, 1'b1);

    // Enable dropped at count 7 for 5 cycles.
    areset();
    for (int i = 1; i <= 7; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      check("gate_sv", longint'(sv8), 0);
      check("gate_out", longint'(out8), 0);
    end
    step(1'b1, 1'b1);
    check("gate_cap_sv", longint'(sv8), 1);
    check("gate_cap_out", longint'(out8), 35);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    check("gate_cap2_out", longint'(out8), 455);

    // Mid-frame asynchronous reset at count 5.
    areset();
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1);
    areset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1);
      if (i < 8) check("mrst_nosv", longint'(sv8), 0);
    end
    check("mrst_cap", longint'(out8), 35);
    check("mrst_sv", longint'(sv8), 1);

    // Constant ones, D=256: pulse width and spacing.
    areset();
    pulses = 0;
    last_pulse = -1;
    for (int i = 1; i <= 600; i++) begin
      step(1'b1, 1'b1);
      if (i == 256) check("d256_cap", longint'(out256), 2731135);
      if (sv256) begin
        if (last_pulse >= 0) check("d256_gap", longint'(i - last_pulse), 256);
        pulses++;
        last_pulse = i;
      end
    end
    check("d256_pulses", longint'(pulses), 2);

    // Randomized input and enable, with occasional asynchronous resets.
    areset();
    for (int i = 0; i < 1800; i++) begin
      if ($urandom_range(0, 599) == 0) areset();
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
